img2col_loader: RTL

IMG2COL_LOADER -- requirements
Module: img2col_loader

---
 rtl/img2col_pkg.sv | 26 ++
 rtl/img2col_addr_gen.sv | 42 ++++
 rtl/img2col_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/img2col_pkg.sv
// Shared definitions for the img2col loader: FSM state encoding, default
// parameter values and the register-pair count per PU.
package img2col_pkg;

  localparam int ROW_DEF         = 28;
  localparam int DATA_WIDTH_DEF  = 16;
  localparam int REG_NUM_DEF     = 20;
  localparam int ADDRESS_NUM_DEF = 5;

  // Two registers are written per beat, so each PU takes REG_NUM/2 beats.
  localparam int PAIRS = REG_NUM_DEF / 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FIRE  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // A round count of zero means a single round.
  function automatic logic [5:0] eff_rounds(input logic [5:0] r);
    return (r == 6'd0) ? 6'd1 : r;
  endfunction

endpackage

// File: rtl/img2col_addr_gen.sv
// Pair counter (k) and PU counter for the LOAD phase. k steps once per
// accepted beat and wraps after the last register pair, advancing the PU.
// last_o flags the final pair of the final PU; stepping on it wraps both.
module img2col_addr_gen #(
  parameter int ROW   = 28,
  parameter int PAIRS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       step_i,
  output logic [5:0] k_o,
  output logic [5:0] pu_o,
  output logic       last_o
);

  localparam logic [5:0] K_LAST  = 6'(PAIRS - 1);
  localparam logic [5:0] PU_LAST = 6'(ROW - 1);

  logic [5:0] k_q;
  logic [5:0] pu_q;

  assign k_o    = k_q;
  assign pu_o   = pu_q;
  assign last_o = (k_q == K_LAST) && (pu_q == PU_LAST);

  // Advance k per accepted beat; wrap into the next PU after the last pair.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      k_q  <= '0;
      pu_q <= '0;
    end else if (step_i) begin
      if (k_q == K_LAST) begin
        k_q  <= '0;
        pu_q <= last_o ? '0 : pu_q + 6'd1;
      end else begin
        k_q <= k_q + 6'd1;
      end
    end
  end

endmodule

// File: rtl/img2col_loader.sv
// img2col loader: streams pixel pairs into a vector of PUs, fires a compute
// pulse, then walks the PU vector for window readout, repeated per round.
// Optional build macro IMG2COL_LOADER_STATS_EN adds beat/stall counters.
//
// state | meaning
// IDLE  | waiting for go
// LOAD  | accepting pixel pairs, writing PU registers
// FIRE  | one-cycle compute trigger
// DRAIN | per-PU readout handshake
// DONE  | one-cycle frame-complete pulse
module img2col_loader
  import img2col_pkg::*;
#(
  parameter int ROW         = ROW_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int REG_NUM     = REG_NUM_DEF,
  parameter int ADDRESS_NUM = ADDRESS_NUM_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [5:0]              cfg_rounds,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  output logic [DATA_WIDTH-1:0]   new1,
  output logic [DATA_WIDTH-1:0]   new2,
  output logic [ADDRESS_NUM-1:0]  adrs_in1,
  output logic [ADDRESS_NUM-1:0]  adrs_in2,
  output logic                    wr_en,
  output logic [5:0]              PU_No,
  output logic [5:0]              round,
  output logic                    start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
`ifdef IMG2COL_LOADER_STATS_EN
  ,
  output logic [31:0]             stat_beats,
  output logic [31:0]             stat_stalls
`endif
);

  localparam int         PAIRS_N = REG_NUM / 2;
  localparam logic [5:0] PU_LAST = 6'(ROW - 1);

  state_e state_q, state_d;

  logic [5:0]             rounds_q;
  logic [5:0]             round_q;
  logic [5:0]             pu_no_q;
  logic [DATA_WIDTH-1:0]  new1_q, new2_q;
  logic [ADDRESS_NUM-1:0] adrs1_q, adrs2_q;
  logic                   wr_en_q, start_q, busy_q, done_q;
  logic                   s_ready_q, out_valid_q;

  logic       accept;
  logic       drain_hs;
  logic       drain_last;
  logic       gen_clr;
  logic [5:0] gen_k, gen_pu;
  logic       gen_last;

  assign accept     = s_valid && s_ready_q;
  assign drain_hs   = out_valid_q && out_ready;
  assign drain_last = drain_hs && (pu_no_q == PU_LAST);

  // Restart pair/PU counting whenever a fresh LOAD phase begins.
  assign gen_clr = (state_d == ST_LOAD) && (state_q != ST_LOAD);

  img2col_addr_gen #(
    .ROW   (ROW),
    .PAIRS (PAIRS_N)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (gen_clr),
    .step_i (accept),
    .k_o    (gen_k),
    .pu_o   (gen_pu),
    .last_o (gen_last)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go) state_d = ST_LOAD;
      ST_LOAD:  if (accept && gen_last) state_d = ST_FIRE;
      ST_FIRE:  state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (drain_last) begin
          state_d = (round_q == (rounds_q - 6'd1)) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register, registered control outputs and the PU write/readout datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rounds_q    <= '0;
      round_q     <= '0;
      pu_no_q     <= '0;
      new1_q      <= '0;
      new2_q      <= '0;
      adrs1_q     <= '0;
      adrs2_q     <= '0;
      wr_en_q     <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != ST_IDLE);
      s_ready_q   <= (state_d == ST_LOAD);
      out_valid_q <= (state_d == ST_DRAIN);
      start_q     <= (state_d == ST_FIRE);
      done_q      <= (state_d == ST_DONE);
      wr_en_q     <= accept;

      // PU_No shows the PU that owns the pair being written this cycle.
      if (accept) begin
        new1_q  <= s_data[DATA_WIDTH-1:0];
        new2_q  <= s_data[2*DATA_WIDTH-1:DATA_WIDTH];
        adrs1_q <= ADDRESS_NUM'({gen_k, 1'b0});
        adrs2_q <= ADDRESS_NUM'({gen_k, 1'b1});
        pu_no_q <= gen_pu;
      end

      case (state_q)
        ST_IDLE: begin
          if (go) begin
            rounds_q <= eff_rounds(cfg_rounds);
            round_q  <= '0;
            pu_no_q  <= '0;
          end
        end
        ST_FIRE: pu_no_q <= '0;
        ST_DRAIN: begin
          if (drain_hs) begin
            if (pu_no_q == PU_LAST) begin
              if (round_q != (rounds_q - 6'd1)) begin
                round_q <= round_q + 6'd1;
                pu_no_q <= '0;
              end
            end else begin
              pu_no_q <= pu_no_q + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign new1      = new1_q;
  assign new2      = new2_q;
  assign adrs_in1  = adrs1_q;
  assign adrs_in2  = adrs2_q;
  assign wr_en     = wr_en_q;
  assign PU_No     = pu_no_q;
  assign round     = round_q;
  assign start     = start_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef IMG2COL_LOADER_STATS_EN
  logic [31:0] stat_beats_q, stat_stalls_q;

  // Saturating counters of accepted beats and stalled readout cycles; cleared per frame.
  always_ff @(posedge clk) begin
    if (rst || ((state_q == ST_IDLE) && go)) begin
      stat_beats_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (accept && (stat_beats_q != '1)) begin
        stat_beats_q <= stat_beats_q + 32'd1;
      end
      if ((state_q == ST_DRAIN) && !out_ready && (stat_stalls_q != '1)) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign stat_beats  = stat_beats_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule
